// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-control definitions: NPC operation codes and fetch FSM states.
package pc_fetch_ctrl_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_npc_target.sv
// Combinational redirect target computation from the NPC operation code.
module npc_target
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [1:0]  redirect_op,
    input  logic [31:0] redirect_pc,
    input  logic [25:0] redirect_imm,
    input  logic [31:0] redirect_jr,
    output logic [31:0] target
);

    logic [31:0] p4;

    always_comb begin
        p4     = pc_plus4(redirect_pc);
        target = p4;
        case (redirect_op)
            NPC_BRANCH: target = p4 + {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
            NPC_JUMP:   target = {p4[31:28], redirect_imm, 2'b00};
            NPC_JR:     target = redirect_jr;
            default:    target = p4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// hands fetched words to decode and squashes wrong-path responses on redirect.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_op,
    input  logic [31:0] redirect_pc,
    input  logic [25:0] redirect_imm,
    input  logic [31:0] redirect_jr,
    output logic [31:0] pc
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc_q;
    logic [31:0]  target;
    logic         kill;

    npc_target u_npc_target (
        .redirect_op  (redirect_op),
        .redirect_pc  (redirect_pc),
        .redirect_imm (redirect_imm),
        .redirect_jr  (redirect_jr),
        .target       (target)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_REQ;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:  if (imem_gnt) state_nxt = S_WAIT;
            S_WAIT: if (imem_rvalid) state_nxt = (kill || redirect_valid) ? S_REQ : S_HOLD;
            S_HOLD: if (redirect_valid || instr_ready) state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        imem_req  = rstn && (state == S_REQ);
        imem_addr = pc_q;
    end

    // kill marks the in-flight response as wrong-path; a redirect arriving
    // together with rvalid drops that response directly and needs no kill.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q        <= RESET_PC;
            kill        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_q <= target;
                        if (imem_gnt) kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (redirect_valid) begin
                            pc_q <= target;
                        end else if (!kill) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc_q;
                            instr_valid <= 1'b1;
                            pc_q        <= pc_plus4(pc_q);
                        end
                    end else if (redirect_valid) begin
                        pc_q <= target;
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        pc_q        <= target;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc = pc_q;

endmodule
